// File: rtl/fp16_mul_normalize.sv
// Sign/exponent datapath and post-normalisation around the fp16 significand multiplier.
// Operand classes travel alongside the multiplier; the product is normalised, rounded (RNE) and packed.
module fp16_mul_normalize #(
   parameter int MUL_LAT = 10
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        in_valid,
   input  logic [15:0] in_a,
   input  logic [15:0] in_b,
   output logic [10:0] sg_a,
   output logic [10:0] sg_b,
   input  logic [21:0] sg_product,
   output logic        out_valid,
   output logic [15:0] out_prod,
   output logic        out_ovf,
   output logic        out_unf,
   output logic        out_inv
);

   localparam int CLS_NAN  = 2;
   localparam int CLS_INF  = 1;
   localparam int CLS_ZERO = 0;

   // Per-operand class {nan, inf, zero}; subnormals count as zero.
   function automatic logic [2:0] classify(input logic [15:0] x);
      logic e_max;
      e_max = (x[14:10] == 5'd31);
      return {e_max & (x[9:0] != 10'd0), e_max & (x[9:0] == 10'd0), x[14:10] == 5'd0};
   endfunction

   function automatic logic [10:0] significand(input logic [15:0] x);
      return (x[14:10] != 5'd0) ? {1'b1, x[9:0]} : 11'd0;
   endfunction

   logic [2:0]  w_cls_a;
   logic [2:0]  w_cls_b;
   logic [2:0]  w_cls;
   logic        w_nan;
   logic        w_inf;
   logic [6:0]  w_esum;

   logic [MUL_LAT-1:0] r_dl_valid;
   logic [MUL_LAT-1:0] r_dl_sign;
   logic [6:0]         r_dl_esum [MUL_LAT];
   logic [2:0]         r_dl_cls  [MUL_LAT];

   logic [9:0]  w_n1_mant;
   logic        w_n1_guard;
   logic        w_n1_sticky;
   logic [6:0]  w_n1_e;

   logic        r_n1_valid;
   logic        r_n1_sign;
   logic [2:0]  r_n1_cls;
   logic [6:0]  r_n1_e;
   logic [9:0]  r_n1_mant;
   logic        r_n1_guard;
   logic        r_n1_sticky;

   logic        w_round_up;
   logic [10:0] w_mant_sum;
   logic [6:0]  w_n2_e;
   logic [15:0] w_res_prod;
   logic        w_res_ovf;
   logic        w_res_unf;
   logic        w_res_inv;

   assign sg_a = significand(in_a);
   assign sg_b = significand(in_b);

   // Combine operand classes with nan > inf > zero precedence; inf x zero is invalid.
   always_comb begin
      w_cls_a = classify(in_a);
      w_cls_b = classify(in_b);
      w_nan   = w_cls_a[CLS_NAN] | w_cls_b[CLS_NAN]
              | (w_cls_a[CLS_INF] & w_cls_b[CLS_ZERO])
              | (w_cls_b[CLS_INF] & w_cls_a[CLS_ZERO]);
      w_inf   = (w_cls_a[CLS_INF] | w_cls_b[CLS_INF]) & ~w_nan;
      w_cls   = {w_nan, w_inf, (w_cls_a[CLS_ZERO] | w_cls_b[CLS_ZERO]) & ~w_nan & ~w_inf};
      w_esum  = {2'b00, in_a[14:10]} + {2'b00, in_b[14:10]} - 7'd15;
   end

   // Delay line matching the multiplier latency.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_dl_valid <= '0;
         r_dl_sign  <= '0;
         for (int i = 0; i < MUL_LAT; i++) begin
            r_dl_esum[i] <= 7'd0;
            r_dl_cls[i]  <= 3'd0;
         end
      end else begin
         r_dl_valid[0] <= in_valid;
         r_dl_sign[0]  <= in_a[15] ^ in_b[15];
         r_dl_esum[0]  <= w_esum;
         r_dl_cls[0]   <= w_cls;
         for (int i = 1; i < MUL_LAT; i++) begin
            r_dl_valid[i] <= r_dl_valid[i-1];
            r_dl_sign[i]  <= r_dl_sign[i-1];
            r_dl_esum[i]  <= r_dl_esum[i-1];
            r_dl_cls[i]   <= r_dl_cls[i-1];
         end
      end
   end

   // Normalise: the product of two [1,2) significands lies in [1,4).
   always_comb begin
      w_n1_mant   = 10'd0;
      w_n1_guard  = 1'b0;
      w_n1_sticky = 1'b0;
      w_n1_e      = 7'd0;
      if (sg_product[21]) begin
         w_n1_mant   = sg_product[20:11];
         w_n1_guard  = sg_product[10];
         w_n1_sticky = |sg_product[9:0];
         w_n1_e      = r_dl_esum[MUL_LAT-1] + 7'd1;
      end else begin
         w_n1_mant   = sg_product[19:10];
         w_n1_guard  = sg_product[9];
         w_n1_sticky = |sg_product[8:0];
         w_n1_e      = r_dl_esum[MUL_LAT-1];
      end
   end

   // N1 stage registers.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_n1_valid  <= 1'b0;
         r_n1_sign   <= 1'b0;
         r_n1_cls    <= 3'd0;
         r_n1_e      <= 7'd0;
         r_n1_mant   <= 10'd0;
         r_n1_guard  <= 1'b0;
         r_n1_sticky <= 1'b0;
      end else begin
         r_n1_valid  <= r_dl_valid[MUL_LAT-1];
         r_n1_sign   <= r_dl_sign[MUL_LAT-1];
         r_n1_cls    <= r_dl_cls[MUL_LAT-1];
         r_n1_e      <= w_n1_e;
         r_n1_mant   <= w_n1_mant;
         r_n1_guard  <= w_n1_guard;
         r_n1_sticky <= w_n1_sticky;
      end
   end

   // Round to nearest even, then resolve the result with special classes taking priority.
   always_comb begin
      w_round_up = r_n1_guard & (r_n1_sticky | r_n1_mant[0]);
      w_mant_sum = {1'b0, r_n1_mant} + {10'd0, w_round_up};
      w_n2_e     = r_n1_e + {6'd0, w_mant_sum[10]};
      w_res_prod = 16'd0;
      w_res_ovf  = 1'b0;
      w_res_unf  = 1'b0;
      w_res_inv  = 1'b0;
      if (r_n1_cls[CLS_NAN]) begin
         w_res_prod = 16'h7E00;
         w_res_inv  = 1'b1;
      end else if (r_n1_cls[CLS_INF]) begin
         w_res_prod = {r_n1_sign, 15'h7C00};
      end else if (r_n1_cls[CLS_ZERO]) begin
         w_res_prod = {r_n1_sign, 15'h0000};
      end else if ($signed(w_n2_e) >= 7'sd31) begin
         w_res_prod = {r_n1_sign, 15'h7C00};
         w_res_ovf  = 1'b1;
      end else if ($signed(w_n2_e) <= 7'sd0) begin
         w_res_prod = {r_n1_sign, 15'h0000};
         w_res_unf  = 1'b1;
      end else begin
         w_res_prod = {r_n1_sign, w_n2_e[4:0], w_mant_sum[9:0]};
      end
   end

   // Output registers hold their last value across bubbles.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         out_valid <= 1'b0;
         out_prod  <= 16'd0;
         out_ovf   <= 1'b0;
         out_unf   <= 1'b0;
         out_inv   <= 1'b0;
      end else begin
         out_valid <= r_n1_valid;
         if (r_n1_valid) begin
            out_prod <= w_res_prod;
            out_ovf  <= w_res_ovf;
            out_unf  <= w_res_unf;
            out_inv  <= w_res_inv;
         end
      end
   end

endmodule

// File: tb/tb_fp16_mul_normalize.sv
// Randomised and directed bench for fp16_mul_normalize with a behavioural multiplier
// and an integer round-to-nearest-even fp16 reference model.
module tb_fp16_mul_normalize;

   localparam int MUL_LAT = 10;

   logic        clock = 1'b0;
   logic        resetn = 1'b1;
   logic        in_valid = 1'b0;
   logic [15:0] in_a = 16'd0;
   logic [15:0] in_b = 16'd0;
   logic [10:0] sg_a;
   logic [10:0] sg_b;
   logic [21:0] sg_product;
   logic        out_valid;
   logic [15:0] out_prod;
   logic        out_ovf;
   logic        out_unf;
   logic        out_inv;

   typedef struct {
      logic [15:0] prod;
      logic        ovf;
      logic        unf;
      logic        inv;
      int          cyc;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   logic [21:0] mul_pipe [MUL_LAT];

   fp16_mul_normalize #(.MUL_LAT(MUL_LAT)) dut (
      .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
      .sg_a(sg_a), .sg_b(sg_b), .sg_product(sg_product), .out_valid(out_valid),
      .out_prod(out_prod), .out_ovf(out_ovf), .out_unf(out_unf), .out_inv(out_inv)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Behavioural significand multiplier with MUL_LAT cycles of latency.
   always @(posedge clock) begin
      mul_pipe[0] <= 22'(sg_a) * 22'(sg_b);
      for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
   end
   assign sg_product = mul_pipe[MUL_LAT-1];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, expv, $time);
      end
   endtask

   function automatic logic [10:0] ref_sig(input logic [15:0] x);
      return (x[14:10] != 5'd0) ? {1'b1, x[9:0]} : 11'd0;
   endfunction

   // Reference result {inv, unf, ovf, prod}: exact integer product rounded by remainder comparison.
   function automatic logic [18:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
      int ea, eb, fa, fb, p, e, sh, q, rem, half;
      logic za, zb, ia, ib, na, nb, s;
      ea = int'(a[14:10]); eb = int'(b[14:10]);
      fa = int'(a[9:0]);   fb = int'(b[9:0]);
      s  = a[15] ^ b[15];
      za = (ea == 0); zb = (eb == 0);
      ia = (ea == 31) && (fa == 0); ib = (eb == 31) && (fb == 0);
      na = (ea == 31) && (fa != 0); nb = (eb == 31) && (fb != 0);
      if (na || nb || (ia && zb) || (ib && za)) return {3'b100, 16'h7E00};
      if (ia || ib) return {3'b000, s, 15'h7C00};
      if (za || zb) return {3'b000, s, 15'h0000};
      p = (1024 + fa) * (1024 + fb);
      e = ea + eb - 15;
      if (p >= (1 << 21)) begin sh = 11; e++; end
      else sh = 10;
      q    = p >> sh;
      rem  = p - (q << sh);
      half = 1 << (sh - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q++;
      if (q == 2048) begin q = 1024; e++; end
      if (e >= 31) return {3'b001, s, 15'h7C00};
      if (e <= 0)  return {3'b010, s, 15'h0000};
      return {3'b000, s, 5'(e), 10'(q)};
   endfunction

   // Scoreboard: results must come out in order at the expected cycle.
   always @(negedge clock) begin
      exp_t e;
      if (resetn && out_valid) begin
         if (exp_q.size() == 0) begin
            check("spurious_valid", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("out_prod", 32'(out_prod), 32'(e.prod));
            check("out_ovf", 32'(out_ovf), 32'(e.ovf));
            check("out_unf", 32'(out_unf), 32'(e.unf));
            check("out_inv", 32'(out_inv), 32'(e.inv));
            check("latency_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b, input logic [18:0] r);
      exp_t item;
      @(posedge clock);
      #1;
      in_valid = v;
      in_a = a;
      in_b = b;
      if (v) begin
         item.prod = r[15:0];
         item.ovf  = r[16];
         item.unf  = r[17];
         item.inv  = r[18];
         item.cyc  = cyc + MUL_LAT + 2;
         exp_q.push_back(item);
      end
      #1;
      check("sg_a", 32'(sg_a), 32'(ref_sig(a)));
      check("sg_b", 32'(sg_b), 32'(ref_sig(b)));
   endtask

   task automatic issue_dir(input logic [15:0] a, input logic [15:0] b, input logic [15:0] p,
                            input logic ovf, input logic unf, input logic inv);
      drive(1'b1, a, b, {inv, unf, ovf, p});
   endtask

   task automatic issue_rnd(input logic [15:0] a, input logic [15:0] b);
      drive(1'b1, a, b, ref_mul(a, b));
   endtask

   task automatic bubble();
      drive(1'b0, 16'($urandom), 16'($urandom), 19'd0);
   endtask

   task automatic drain();
      int budget = 0;
      bubble();
      while (exp_q.size() > 0 && budget < 200) begin
         @(negedge clock);
         budget++;
      end
      if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   function automatic logic [15:0] rnd_normal();
      return {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
   endfunction

   initial begin
      #2 resetn = 1'b0;
      #1;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_prod", 32'(out_prod), 32'd0);
      check("rst_flags", 32'({out_ovf, out_unf, out_inv}), 32'd0);
      repeat (2) @(posedge clock);
      #3 resetn = 1'b1;

      // Directed cases
      issue_dir(16'h3C00, 16'h3C00, 16'h3C00, 1'b0, 1'b0, 1'b0);
      issue_dir(16'h3E00, 16'h3E00, 16'h4080, 1'b0, 1'b0, 1'b0);
      issue_dir(16'h3C01, 16'h3C01, 16'h3C02, 1'b0, 1'b0, 1'b0);
      issue_dir(16'h7800, 16'h7800, 16'h7C00, 1'b1, 1'b0, 1'b0);
      issue_dir(16'h0400, 16'h0400, 16'h0000, 1'b0, 1'b1, 1'b0);
      issue_dir(16'h8400, 16'h0400, 16'h8000, 1'b0, 1'b1, 1'b0);
      issue_dir(16'h7C00, 16'h0000, 16'h7E00, 1'b0, 1'b0, 1'b1);
      issue_dir(16'h7E01, 16'h3C00, 16'h7E00, 1'b0, 1'b0, 1'b1);
      issue_dir(16'hFC00, 16'h3C00, 16'hFC00, 1'b0, 1'b0, 1'b0);
      issue_dir(16'h0001, 16'h3C00, 16'h0000, 1'b0, 1'b0, 1'b0);
      drain();

      // Random normal operands with bubbles
      for (int i = 0; i < 20; i++) begin
         issue_rnd(rnd_normal(), rnd_normal());
         if ($urandom_range(0, 2) == 0) bubble();
      end
      // Unconstrained bit patterns reach specials and subnormals
      for (int i = 0; i < 30; i++) begin
         issue_rnd(16'($urandom), 16'($urandom));
         if ($urandom_range(0, 3) == 0) bubble();
      end
      issue_dir(16'h3C00, 16'h3E00, 16'h3E00, 1'b0, 1'b0, 1'b0);
      drain();

      // Asynchronous reset with operations in flight
      for (int i = 0; i < 5; i++) issue_rnd(rnd_normal(), rnd_normal());
      in_valid = 1'b0;
      @(posedge clock);
      #3 resetn = 1'b0;
      #1;
      check("async_rst_valid", 32'(out_valid), 32'd0);
      check("async_rst_prod", 32'(out_prod), 32'd0);
      check("async_rst_flags", 32'({out_ovf, out_unf, out_inv}), 32'd0);
      exp_q.delete();
      @(posedge clock);
      #3 resetn = 1'b1;
      for (int i = 0; i < MUL_LAT + 4; i++) begin
         @(negedge clock);
         check("stale_valid", 32'(out_valid), 32'd0);
      end
      issue_dir(16'h3C00, 16'h3E00, 16'h3E00, 1'b0, 1'b0, 1'b0);
      drain();
      repeat (3) @(negedge clock);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
